// File: rtl/gemm_skew_delay.sv
// gemm_skew_delay
//
// Multi-lane delay line that skews (C_MODE = 0) or de-skews (C_MODE = 1) a packed vector of
// operand lanes for the systolic GEMM array. Lane i is delayed by
//   skew    : D_i = C_BASE + C_STEP * i
//   de-skew : D_i = C_BASE + C_STEP * (C_CHANNELS - 1 - i)
// Every lane carries a valid bit with its data. A block ends with in_last; the last tag rides
// a DMAX-stage pipe beside the deepest lane, and new beats are refused until it leaves.
//
// Ports
//   clock      sole clock, rising edge
//   reset_n    asynchronous active-low reset
//   enable     advance; low freezes every stage, the counter and the state
//   flush      synchronous drop of all in-flight beats (overrides enable and in_valid)
//   in_valid   input beat valid (all lanes)
//   in_last    final beat of a block, qualified by in_valid
//   in_ready   high unless draining; beat taken on in_valid & in_ready & enable & !flush
//   in_data    C_CHANNELS lanes, lane i at [i*C_DATA_WIDTH +: C_DATA_WIDTH]
//   out_valid  per-lane valid
//   out_data   same packing as in_data
//   out_last   last tag leaving the deepest lane
//   busy       state not idle, or any valid/last bit in flight
//
// Build option
//   GEMM_SKEW_ZEROFILL_EN  defined: stages load zero data behind a bubble.
//                          undefined: data registers load only on a valid beat (lower toggle).

module gemm_skew_delay #(
   parameter int unsigned C_DATA_WIDTH = 32,
   parameter int unsigned C_CHANNELS   = 4,
   parameter int unsigned C_STEP       = 1,
   parameter int unsigned C_BASE       = 0,
   parameter int unsigned C_MODE       = 0
) (
   input  logic                                 clock,
   input  logic                                 reset_n,
   input  logic                                 enable,
   input  logic                                 flush,
   input  logic                                 in_valid,
   input  logic                                 in_last,
   output logic                                 in_ready,
   input  logic [C_CHANNELS*C_DATA_WIDTH-1:0]   in_data,
   output logic [C_CHANNELS-1:0]                out_valid,
   output logic [C_CHANNELS*C_DATA_WIDTH-1:0]   out_data,
   output logic                                 out_last,
   output logic                                 busy
);

   localparam int unsigned DMAX = C_BASE + C_STEP * (C_CHANNELS - 1);
   localparam int unsigned CW   = (DMAX > 0) ? $clog2(DMAX + 1) : 1;
   localparam logic [CW-1:0] DMAX_C = CW'(DMAX);

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDrain
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
   logic            accept;
   logic [C_CHANNELS-1:0] lane_busy;
   logic            last_busy;

   assign in_ready = (state_q != StDrain);

   // Gating with reset_n keeps depth-0 lanes and the DMAX = 0 last path quiet while in reset.
   assign accept = in_valid & in_ready & enable & ~flush & reset_n;

   // ---------------------------------------------------------------------------------------
   // Per-lane delay lines
   // ---------------------------------------------------------------------------------------
   for (genvar i = 0; i < int'(C_CHANNELS); i++) begin : g_lane
      localparam int unsigned IDX = i;
      localparam int unsigned D   = (C_MODE == 0) ? (C_BASE + C_STEP * IDX)
                                                  : (C_BASE + C_STEP * (C_CHANNELS - 1 - IDX));

      logic [C_DATA_WIDTH-1:0] lane_in;
      assign lane_in = in_data[IDX*C_DATA_WIDTH +: C_DATA_WIDTH];

      if (D == 0) begin : g_pass
         assign out_valid[IDX]                              = accept;
         assign out_data[IDX*C_DATA_WIDTH +: C_DATA_WIDTH] = lane_in;
         assign lane_busy[IDX]                              = 1'b0;
      end else begin : g_pipe
         logic [D-1:0]            vld_q;
         logic [C_DATA_WIDTH-1:0] dat_q [D];
         logic [D-1:0]            vin;
         logic [C_DATA_WIDTH-1:0] din [D];

         // Incoming {valid, data} of each stage.
         always_comb begin
            vin[0] = accept;
            din[0] = lane_in;
            for (int k = 1; k < int'(D); k++) begin
               vin[k] = vld_q[k-1];
               din[k] = dat_q[k-1];
            end
         end

         always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
               vld_q <= '0;
               for (int k = 0; k < int'(D); k++) begin
                  dat_q[k] <= '0;
               end
            end else if (flush) begin
               // Data registers are left alone; only the valid bits are dropped.
               vld_q <= '0;
            end else if (enable) begin
               vld_q <= vin;
               for (int k = 0; k < int'(D); k++) begin
`ifdef GEMM_SKEW_ZEROFILL_EN
                  dat_q[k] <= vin[k] ? din[k] : '0;
`else
                  if (vin[k]) begin
                     dat_q[k] <= din[k];
                  end
`endif
               end
            end
         end

         assign out_valid[IDX]                              = vld_q[D-1];
         assign out_data[IDX*C_DATA_WIDTH +: C_DATA_WIDTH] = dat_q[D-1];
         assign lane_busy[IDX]                              = |vld_q;
      end
   end

   // ---------------------------------------------------------------------------------------
   // Last tag, travelling beside the deepest lane
   // ---------------------------------------------------------------------------------------
   if (DMAX == 0) begin : g_last_comb
      assign out_last  = accept & in_last;
      assign last_busy = 1'b0;
   end else begin : g_last_pipe
      logic [DMAX-1:0] last_q;

      always_ff @(posedge clock or negedge reset_n) begin
         if (!reset_n) begin
            last_q <= '0;
         end else if (flush) begin
            last_q <= '0;
         end else if (enable) begin
            last_q[0] <= accept & in_last;
            for (int k = 1; k < int'(DMAX); k++) begin
               last_q[k] <= last_q[k-1];
            end
         end
      end

      assign out_last  = last_q[DMAX-1];
      assign last_busy = |last_q;
   end

   // ---------------------------------------------------------------------------------------
   // Block state machine and drain counter
   // ---------------------------------------------------------------------------------------
   assign cnt_inc = cnt_q + CW'(1);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (flush) begin
         state_d = StIdle;
         cnt_d   = '0;
      end else if (enable) begin
         case (state_q)
            StIdle, StRun: begin
               if (accept) begin
                  if (!in_last) begin
                     state_d = StRun;
                  end else if (DMAX == 0) begin
                     // out_last already fired combinationally; nothing left to drain.
                     state_d = StIdle;
                  end else begin
                     state_d = StDrain;
                     cnt_d   = '0;
                  end
               end
            end
            StDrain: begin
               if (out_last) begin
                  state_d = StIdle;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign busy = (state_q != StIdle) | (|lane_busy) | last_busy;

   // The drain counter and the last-tag pipe are independent; they must agree.
   a_drain_end : assert property (@(posedge clock) disable iff (!reset_n)
      (enable && !flush && state_q == StDrain && out_last) |-> (cnt_inc == DMAX_C));

   a_drain_run : assert property (@(posedge clock) disable iff (!reset_n)
      (enable && !flush && state_q == StDrain && !out_last) |-> (cnt_inc < DMAX_C));

endmodule

// File: tb/tb_gemm_skew_delay.sv
// tb_gemm_skew_delay
//
// Directed bench for gemm_skew_delay. Three instances share one stimulus bus:
//   u_skew  default skew (depths 0,1,2,3; DMAX = 3)
//   u_desk  de-skew      (depths 3,2,1,0)
//   u_zero  C_STEP = 0   (DMAX = 0, all lanes combinational)
// Each phase starts from reset and checks only the instance it targets.
// Honours GEMM_SKEW_ZEROFILL_EN for the bubble-data check.

module tb_gemm_skew_delay;

   localparam int unsigned W  = 32;
   localparam int unsigned CH = 4;
   localparam logic [31:0] Z  = '0;

   logic              clock = 1'b0;
   logic              reset_n;
   logic              enable;
   logic              flush;
   logic              in_valid;
   logic              in_last;
   logic [CH*W-1:0]   in_data;

   logic              s_ready, d_ready, z_ready;
   logic [CH-1:0]     s_valid, d_valid, z_valid;
   logic [CH*W-1:0]   s_data, d_data, z_data;
   logic              s_last, d_last, z_last;
   logic              s_busy, d_busy, z_busy;

   always #5 clock = ~clock;

   gemm_skew_delay #(
      .C_DATA_WIDTH(W), .C_CHANNELS(CH), .C_STEP(1), .C_BASE(0), .C_MODE(0)
   ) u_skew (
      .clock(clock), .reset_n(reset_n), .enable(enable), .flush(flush),
      .in_valid(in_valid), .in_last(in_last), .in_ready(s_ready), .in_data(in_data),
      .out_valid(s_valid), .out_data(s_data), .out_last(s_last), .busy(s_busy)
   );

   gemm_skew_delay #(
      .C_DATA_WIDTH(W), .C_CHANNELS(CH), .C_STEP(1), .C_BASE(0), .C_MODE(1)
   ) u_desk (
      .clock(clock), .reset_n(reset_n), .enable(enable), .flush(flush),
      .in_valid(in_valid), .in_last(in_last), .in_ready(d_ready), .in_data(in_data),
      .out_valid(d_valid), .out_data(d_data), .out_last(d_last), .busy(d_busy)
   );

   gemm_skew_delay #(
      .C_DATA_WIDTH(W), .C_CHANNELS(CH), .C_STEP(0), .C_BASE(0), .C_MODE(0)
   ) u_zero (
      .clock(clock), .reset_n(reset_n), .enable(enable), .flush(flush),
      .in_valid(in_valid), .in_last(in_last), .in_ready(z_ready), .in_data(in_data),
      .out_valid(z_valid), .out_data(z_data), .out_last(z_last), .busy(z_busy)
   );

   // ctrl = {enable, in_valid, in_last}; flags = {in_ready, out_last, busy}
   typedef struct packed {
      logic [2:0]      ctrl;
      logic [CH*W-1:0] data;
      logic [CH-1:0]   ev;
      logic [2:0]      flags;
      logic [CH*W-1:0] ed;
   } vec_t;

   localparam int NV = 24;
   vec_t tv [NV];

   int n_checks = 0;
   int n_fail   = 0;

   function automatic logic [CH*W-1:0] pack4(input logic [31:0] a3, input logic [31:0] a2,
                                             input logic [31:0] a1, input logic [31:0] a0);
      return {a3, a2, a1, a0};
   endfunction

   // Value of lane j in beat k.
   function automatic logic [31:0] lv(input int k, input int j);
      return 32'hB000_0000 + 32'(k * 256 + j);
   endfunction

   function automatic logic [CH*W-1:0] beat(input int k);
      return pack4(lv(k, 3), lv(k, 2), lv(k, 1), lv(k, 0));
   endfunction

   function automatic vec_t vec(input logic [2:0] ctrl, input logic [CH*W-1:0] data,
                                input logic [CH-1:0] ev, input logic [2:0] flags,
                                input logic [CH*W-1:0] ed);
      vec_t r;
      r.ctrl  = ctrl;
      r.data  = data;
      r.ev    = ev;
      r.flags = flags;
      r.ed    = ed;
      return r;
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      enable   = 1'b1;
      flush    = 1'b0;
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = '0;
      reset_n  = 1'b0;
      @(posedge clock);
      #1;
      reset_n  = 1'b1;
   endtask

   task automatic drive(input logic [2:0] ctrl, input logic [CH*W-1:0] data);
      {enable, in_valid, in_last} = ctrl;
      in_data = data;
   endtask

   initial begin
      // Skew of one beat, then stall stream, then drain of a 3-beat block (u_skew).
      tv[0]  = vec(3'b110, pack4(32'h13, 32'h12, 32'h11, 32'h10), 4'b0001, 3'b100,
                   pack4(Z, Z, Z, 32'h10));
      tv[1]  = vec(3'b100, '0, 4'b0010, 3'b101, pack4(Z, Z, 32'h11, Z));
      tv[2]  = vec(3'b100, '0, 4'b0100, 3'b101, pack4(Z, 32'h12, Z, Z));
      tv[3]  = vec(3'b100, '0, 4'b1000, 3'b101, pack4(32'h13, Z, Z, Z));
      tv[4]  = vec(3'b100, '0, 4'b0000, 3'b101, '0);
      tv[5]  = vec(3'b110, beat(0), 4'b0001, 3'b101, pack4(Z, Z, Z, lv(0, 0)));
      tv[6]  = vec(3'b110, beat(1), 4'b0011, 3'b101, pack4(Z, Z, lv(0, 1), lv(1, 0)));
      tv[7]  = vec(3'b010, beat(2), 4'b0110, 3'b101, pack4(Z, lv(0, 2), lv(1, 1), Z));
      tv[8]  = vec(3'b010, beat(2), 4'b0110, 3'b101, pack4(Z, lv(0, 2), lv(1, 1), Z));
      tv[9]  = vec(3'b110, beat(2), 4'b0111, 3'b101, pack4(Z, lv(0, 2), lv(1, 1), lv(2, 0)));
      tv[10] = vec(3'b110, beat(3), 4'b1111, 3'b101,
                   pack4(lv(0, 3), lv(1, 2), lv(2, 1), lv(3, 0)));
      tv[11] = vec(3'b110, beat(4), 4'b1111, 3'b101,
                   pack4(lv(1, 3), lv(2, 2), lv(3, 1), lv(4, 0)));
      tv[12] = vec(3'b100, '0, 4'b1110, 3'b101, pack4(lv(2, 3), lv(3, 2), lv(4, 1), Z));
      tv[13] = vec(3'b100, '0, 4'b1100, 3'b101, pack4(lv(3, 3), lv(4, 2), Z, Z));
      tv[14] = vec(3'b100, '0, 4'b1000, 3'b101, pack4(lv(4, 3), Z, Z, Z));
      tv[15] = vec(3'b100, '0, 4'b0000, 3'b101, '0);
      tv[16] = vec(3'b110, beat(5), 4'b0001, 3'b101, pack4(Z, Z, Z, lv(5, 0)));
      tv[17] = vec(3'b110, beat(6), 4'b0011, 3'b101, pack4(Z, Z, lv(5, 1), lv(6, 0)));
      tv[18] = vec(3'b111, beat(7), 4'b0111, 3'b101, pack4(Z, lv(5, 2), lv(6, 1), lv(7, 0)));
      tv[19] = vec(3'b110, beat(8), 4'b1110, 3'b001, pack4(lv(5, 3), lv(6, 2), lv(7, 1), Z));
      tv[20] = vec(3'b110, beat(8), 4'b1100, 3'b001, pack4(lv(6, 3), lv(7, 2), Z, Z));
      tv[21] = vec(3'b110, beat(8), 4'b1000, 3'b011, pack4(lv(7, 3), Z, Z, Z));
      tv[22] = vec(3'b110, beat(8), 4'b0001, 3'b100, pack4(Z, Z, Z, lv(8, 0)));
      tv[23] = vec(3'b100, '0, 4'b0010, 3'b101, pack4(Z, Z, lv(8, 1), Z));

      // Reset values, checked while reset is still asserted.
      enable   = 1'b1;
      flush    = 1'b0;
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = beat(0);
      reset_n  = 1'b0;
      #3;
      check("reset out_valid", 128'(s_valid), 128'(4'b0000));
      check("reset out_last", 128'(s_last), 128'(1'b0));
      check("reset busy", 128'(s_busy), 128'(1'b0));
      check("reset in_ready", 128'(s_ready), 128'(1'b1));
      check("reset out_data", 128'(s_data), 128'(pack4(Z, Z, Z, lv(0, 0))));
      @(posedge clock);
      #1;
      reset_n = 1'b1;

      // Table-driven vectors.
      for (int c = 0; c < NV; c++) begin
         drive(tv[c].ctrl, tv[c].data);
         @(negedge clock);
         check($sformatf("vec%0d out_valid", c), 128'(s_valid), 128'(tv[c].ev));
         check($sformatf("vec%0d in_ready", c), 128'(s_ready), 128'(tv[c].flags[2]));
         check($sformatf("vec%0d out_last", c), 128'(s_last), 128'(tv[c].flags[1]));
         check($sformatf("vec%0d busy", c), 128'(s_busy), 128'(tv[c].flags[0]));
         for (int j = 0; j < int'(CH); j++) begin
            if (tv[c].ev[j]) begin
               check($sformatf("vec%0d data lane%0d", c, j),
                     128'(s_data[j*W +: W]), 128'(tv[c].ed[j*W +: W]));
            end
         end
         cyc();
      end

      // Flush: two beats (second ends the block), then flush with a beat presented.
      do_reset();
      drive(3'b110, beat(0));
      cyc();
      drive(3'b111, beat(1));
      cyc();
      drive(3'b110, beat(2));
      flush = 1'b1;
      @(negedge clock);
      check("flush lane0 valid", 128'(s_valid[0]), 128'(1'b0));
      check("flush in_ready draining", 128'(s_ready), 128'(1'b0));
      cyc();
      flush = 1'b0;
      drive(3'b100, '0);
      for (int c = 0; c < 4; c++) begin
         @(negedge clock);
         check($sformatf("post-flush%0d out_valid", c), 128'(s_valid), 128'(4'b0000));
         check($sformatf("post-flush%0d out_last", c), 128'(s_last), 128'(1'b0));
         check($sformatf("post-flush%0d busy", c), 128'(s_busy), 128'(1'b0));
         check($sformatf("post-flush%0d in_ready", c), 128'(s_ready), 128'(1'b1));
         cyc();
      end
      drive(3'b110, beat(3));
      cyc();
      drive(3'b100, '0);
      cyc();
      cyc();
      @(negedge clock);
      check("post-flush beat valid", 128'(s_valid), 128'(4'b1000));
      check("post-flush beat lane3", 128'(s_data[3*W +: W]), 128'(lv(3, 3)));
      cyc();

      // De-skew: lane k fed at t0+k lines all four lanes up at t0+3.
      do_reset();
      for (int k = 0; k < 5; k++) begin
         logic [CH-1:0] ev;
         if (k < 4) begin
            in_data = {4{32'hEEEE_EEEE}};
            in_data[k*W +: W] = 32'h0000_00A0 + 32'(k);
            drive(3'b110, in_data);
         end else begin
            drive(3'b100, '0);
         end
         case (k)
            0:       ev = 4'b1000;
            1:       ev = 4'b1100;
            2:       ev = 4'b1110;
            3:       ev = 4'b1111;
            default: ev = 4'b0111;
         endcase
         @(negedge clock);
         check($sformatf("deskew t%0d out_valid", k), 128'(d_valid), 128'(ev));
         check($sformatf("deskew t%0d in_ready", k), 128'(d_ready), 128'(1'b1));
         if (k == 3) begin
            check("deskew aligned data", 128'(d_data),
                  128'(pack4(32'hA3, 32'hA2, 32'hA1, 32'hA0)));
         end
         cyc();
      end
      @(negedge clock);
      check("deskew busy", 128'(d_busy), 128'(1'b1));
      check("deskew out_last", 128'(d_last), 128'(1'b0));
      cyc();

      // DMAX = 0: out_last is combinational and the state never leaves idle.
      do_reset();
      drive(3'b111, beat(0));
      @(negedge clock);
      check("dmax0 out_last", 128'(z_last), 128'(1'b1));
      check("dmax0 out_valid", 128'(z_valid), 128'(4'b1111));
      check("dmax0 out_data", 128'(z_data), 128'(beat(0)));
      cyc();
      drive(3'b011, beat(1));
      @(negedge clock);
      check("dmax0 stall out_valid", 128'(z_valid), 128'(4'b0000));
      check("dmax0 stall out_last", 128'(z_last), 128'(1'b0));
      check("dmax0 stall in_ready", 128'(z_ready), 128'(1'b1));
      cyc();
      drive(3'b100, '0);
      @(negedge clock);
      check("dmax0 busy", 128'(z_busy), 128'(1'b0));
      check("dmax0 in_ready", 128'(z_ready), 128'(1'b1));
      cyc();

      // Asynchronous reset while out_last is showing.
      do_reset();
      drive(3'b111, beat(4));
      cyc();
      drive(3'b100, '0);
      @(negedge clock);
      check("drain in_ready", 128'(s_ready), 128'(1'b0));
      cyc();
      cyc();
      @(negedge clock);
      check("pre-reset out_last", 128'(s_last), 128'(1'b1));
      #2;
      reset_n = 1'b0;
      #1;
      check("async reset out_valid", 128'(s_valid), 128'(4'b0000));
      check("async reset out_last", 128'(s_last), 128'(1'b0));
      check("async reset busy", 128'(s_busy), 128'(1'b0));
      check("async reset in_ready", 128'(s_ready), 128'(1'b1));
      @(posedge clock);
      #1;
      reset_n = 1'b1;

      // Data behind a bubble: zero in the zero-fill build, held otherwise.
      do_reset();
      drive(3'b110, beat(9));
      cyc();
      drive(3'b100, '0);
      cyc();
      @(negedge clock);
`ifdef GEMM_SKEW_ZEROFILL_EN
      check("bubble lane1 data", 128'(s_data[1*W +: W]), 128'(Z));
`else
      check("bubble lane1 data", 128'(s_data[1*W +: W]), 128'(lv(9, 1)));
`endif
      cyc();
      @(negedge clock);
      check("bubble lane3 valid", 128'(s_valid), 128'(4'b1000));
      check("bubble lane3 beat", 128'(s_data[3*W +: W]), 128'(lv(9, 3)));
      cyc();
      @(negedge clock);
`ifdef GEMM_SKEW_ZEROFILL_EN
      check("bubble lane3 data", 128'(s_data[3*W +: W]), 128'(Z));
`else
      check("bubble lane3 data", 128'(s_data[3*W +: W]), 128'(lv(9, 3)));
`endif
      cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
